// File: rtl/lcd_init_sender.sv
// Power-on sequencer for an ST7735-class panel: pulses the hardware reset, then
// streams the command ROM out over 4-wire SPI (mode 0, MSB first).
module lcd_init_sender #(
  parameter int CMD_COUNT       = 85,
  parameter int CLK_DIV         = 4,
  parameter int RST_LOW_CYC     = 1000,
  parameter int RST_WAIT_CYC    = 1000,
  parameter int SLPOUT_WAIT_CYC = 6000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [15:0] rom_addr,
  input  logic [7:0]  rom_data,
  input  logic        rom_dc,
  output logic        lcd_rst_n,
  output logic        lcd_cs_n,
  output logic        lcd_dc,
  output logic        lcd_sclk,
  output logic        lcd_mosi,
  output logic        busy,
  output logic        done
);

  localparam logic [15:0] LAST_ADDR = 16'(CMD_COUNT - 1);
  localparam logic [31:0] RST_LOW_LAST  = 32'(RST_LOW_CYC - 1);
  localparam logic [31:0] RST_WAIT_LAST = 32'(RST_WAIT_CYC - 1);
  localparam logic [31:0] SLP_LAST      = 32'(SLPOUT_WAIT_CYC - 1);
  localparam logic [31:0] HALF_LAST     = 32'(CLK_DIV - 1);
  localparam logic [31:0] BIT_LAST      = 32'(2 * CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE, RST_LOW, RST_WAIT, LOAD, SHIFT, GAP, SLP_WAIT, DONE
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic [7:0]  byte_q;
  logic        last_addr;
  logic        sleep_cmd;

  always_comb begin
    state_nxt = state;
    last_addr = (rom_addr == LAST_ADDR);
    sleep_cmd = (byte_q == 8'h11) && !lcd_dc;
    case (state)
      IDLE, DONE: if (start) state_nxt = RST_LOW;
      RST_LOW:    if (cnt == RST_LOW_LAST) state_nxt = RST_WAIT;
      RST_WAIT:   if (cnt == RST_WAIT_LAST) state_nxt = LOAD;
      LOAD:       state_nxt = SHIFT;
      SHIFT:      if (cnt == BIT_LAST && bit_cnt == 3'd7) state_nxt = GAP;
      GAP:        if (cnt == 32'd1)
                    state_nxt = sleep_cmd ? SLP_WAIT : (last_addr ? DONE : LOAD);
      SLP_WAIT:   if (cnt == SLP_LAST) state_nxt = last_addr ? DONE : LOAD;
      default:    state_nxt = IDLE;
    endcase
  end

  // Outputs are updated on the edge that enters a state, so CS is low for
  // LOAD+SHIFT and high for exactly the GAP cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      byte_q    <= '0;
      rom_addr  <= '0;
      lcd_rst_n <= 1'b1;
      lcd_cs_n  <= 1'b1;
      lcd_dc    <= 1'b0;
      lcd_sclk  <= 1'b0;
      lcd_mosi  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)
        cnt <= '0;
      else if (state == SHIFT && cnt == BIT_LAST)
        cnt <= '0;
      else if (state != IDLE && state != DONE)
        cnt <= cnt + 32'd1;

      case (state)
        IDLE, DONE: if (start) begin
          rom_addr  <= '0;
          lcd_rst_n <= 1'b0;
          busy      <= 1'b1;
          done      <= 1'b0;
        end
        RST_LOW:  if (state_nxt == RST_WAIT) lcd_rst_n <= 1'b1;
        RST_WAIT: if (state_nxt == LOAD) lcd_cs_n <= 1'b0;
        LOAD: begin
          shreg    <= rom_data;
          byte_q   <= rom_data;
          lcd_dc   <= rom_dc;
          lcd_mosi <= rom_data[7];
          bit_cnt  <= '0;
        end
        SHIFT: begin
          if (cnt == HALF_LAST) lcd_sclk <= 1'b1;
          // MOSI advances only as SCLK falls, keeping it stable across rising edges
          if (cnt == BIT_LAST) begin
            lcd_sclk <= 1'b0;
            if (bit_cnt == 3'd7) begin
              lcd_cs_n <= 1'b1;
            end else begin
              shreg    <= {shreg[6:0], 1'b0};
              lcd_mosi <= shreg[6];
              bit_cnt  <= bit_cnt + 3'd1;
            end
          end
        end
        GAP, SLP_WAIT: begin
          if (state_nxt == LOAD) begin
            rom_addr <= rom_addr + 16'd1;
            lcd_cs_n <= 1'b0;
          end
          if (state_nxt == DONE) begin
            done <= 1'b1;
            busy <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
